// File: rtl/regex_table_loader_pkg.sv
// regex_table_loader_pkg: shared constants, entry field positions and FSM encoding
// for the regex table write-side loader.
package regex_table_loader_pkg;
    localparam int TBL_ADDR_W  = 14;
    localparam int TBL_ENTRY_W = 15;
    localparam int PORT_W      = TBL_ADDR_W + TBL_ENTRY_W;
    localparam logic [PORT_W-1:0] IDLE_CODE = '0;
    localparam int MATCH_BIT = 14;
    localparam int STAGE_MSB = 12;
    localparam int STAGE_LSB = 0;
    localparam int CNT_W = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_GAP,
        S_CLR_HOLD,
        S_CLR_GAP
    } state_e;
endpackage

// File: rtl/regex_table_loader_fifo.sv
// fallthrough_small_fifo: small first-word-fallthrough FIFO; dout shows the head entry
// whenever empty is low.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 29,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [MAX_DEPTH_BITS:0] CNT_ONE = 1;
    localparam logic [MAX_DEPTH_BITS:0] CNT_FULL = (MAX_DEPTH_BITS+1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0] count_q;
    logic push, pop;
    assign full  = count_q == CNT_FULL;
    assign empty = count_q == '0;
    assign dout  = mem_q[rd_ptr_q];
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            count_q  <= (push && !pop) ? count_q + CNT_ONE :
                        (pop && !push) ? count_q - CNT_ONE : count_q;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/regex_table_loader.sv
// regex_table_loader: buffers table-entry writes and replays them on the regex_match write
// port with hold/idle framing; also sweeps the whole table to zero on request.
module regex_table_loader
    import regex_table_loader_pkg::*;
#(
    parameter int TABLE_ADDR_WIDTH = TBL_ADDR_W,
    parameter int ENTRY_WIDTH      = TBL_ENTRY_W,
    parameter int HOLD_CYCLES      = 2,
    parameter int GAP_CYCLES       = 1,
    parameter int FIFO_DEPTH_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_req,
    input  logic [TABLE_ADDR_WIDTH-1:0] wr_addr,
    input  logic [ENTRY_WIDTH-1:0]      wr_data,
    output logic                        wr_ack,
    input  logic                        clear_req,
    output logic                        clear_busy,
    output logic [ENTRY_WIDTH-1:0]      regex_din,
    output logic [TABLE_ADDR_WIDTH-1:0] regex_in_addr,
    output logic                        loader_idle,
    output logic [15:0]                 entries_written,
    output logic [15:0]                 entries_rejected
);
    localparam int PW = TABLE_ADDR_WIDTH + ENTRY_WIDTH;
    localparam logic [TABLE_ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TABLE_ADDR_WIDTH-1:0] addr_q, addr_d, clr_addr_q, clr_addr_d;
    logic [ENTRY_WIDTH-1:0] din_q, din_d;
    logic clr_busy_q, clr_busy_d, ack_q, ack_d;
    logic [15:0] written_q, written_d, rejected_q, rejected_d;
    logic entry_zero, consume, push, pop, launch, written_inc;
    logic fifo_full, fifo_empty;
    logic [PW-1:0] fifo_dout;

    // A zero entry would look like the idle code, so it is acked but never queued.
    assign entry_zero = (wr_addr == '0) && (wr_data == '0);
    assign push       = wr_req && !ack_q && !entry_zero && !fifo_full && !clr_busy_q;
    assign consume    = wr_req && !ack_q && (entry_zero || (!fifo_full && !clr_busy_q));
    assign ack_d      = consume;
    assign written_d  = (written_inc && written_q != 16'hFFFF) ? written_q + 16'd1 : written_q;
    assign rejected_d = (consume && entry_zero && rejected_q != 16'hFFFF) ? rejected_q + 16'd1 : rejected_q;

    fallthrough_small_fifo #(
        .WIDTH         (PW),
        .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .din  ({wr_addr, wr_data}),
        .wr_en(push),
        .rd_en(pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        addr_d      = addr_q;
        din_d       = din_q;
        clr_addr_d  = clr_addr_q;
        clr_busy_d  = clr_busy_q | clear_req;
        pop         = 1'b0;
        launch      = 1'b0;
        written_inc = 1'b0;
        case (state_q)
            S_IDLE: launch = 1'b1;
            S_HOLD, S_CLR_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    {addr_d, din_d} = PW'(IDLE_CODE);
                    cnt_d           = '0;
                    state_d         = (state_q == S_HOLD) ? S_GAP : S_CLR_GAP;
                    written_inc     = state_q == S_HOLD;
                end
            end
            // The last gap cycle launches the next entry directly to sustain HOLD+GAP throughput.
            S_GAP: launch = cnt_q == GAP_LAST;
            S_CLR_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    clr_addr_d = clr_addr_q + ADDR_ONE;
                    addr_d     = clr_addr_q + ADDR_ONE;
                    state_d    = (clr_addr_q == '1) ? S_IDLE : S_CLR_HOLD;
                    clr_busy_d = clr_addr_q != '1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            cnt_d = '0;
            if (clr_busy_q && fifo_empty) begin
                state_d    = S_CLR_HOLD;
                clr_addr_d = ADDR_ONE;
                addr_d     = ADDR_ONE;
                din_d      = '0;
            end else if (!fifo_empty) begin
                pop             = 1'b1;
                {addr_d, din_d} = fifo_dout;
                state_d         = S_HOLD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b0;
            ack_q      <= 1'b0;
            written_q  <= '0;
            rejected_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            clr_addr_q <= clr_addr_d;
            clr_busy_q <= clr_busy_d;
            ack_q      <= ack_d;
            written_q  <= written_d;
            rejected_q <= rejected_d;
        end
    end

    assign wr_ack           = ack_q;
    assign clear_busy       = clr_busy_q;
    assign regex_din        = din_q;
    assign regex_in_addr    = addr_q;
    assign loader_idle      = fifo_empty && state_q == S_IDLE && !clr_busy_q;
    assign entries_written  = written_q;
    assign entries_rejected = rejected_q;
endmodule

// File: doc/regex_table_loader.md
# regex_table_loader

Write-side driver for the regex state-transition BRAM inside `regex_match`. Accepts table-entry writes from the register interface, buffers them, and replays each one on the `regex_din` / `regex_in_addr` write port with the hold/idle framing that port requires. Also provides a bulk-clear sweep over the table. Sits between the register block and `regex_match` in the packet_eval_output pipeline.

## Interface
- `TABLE_ADDR_WIDTH`, 14, BRAM address width (table of 2^14 entries).
- `ENTRY_WIDTH`, 15, entry width: bit 14 = match flag, bits 12:0 = next stage, bit 13 reserved (written as given).
- `HOLD_CYCLES`, 2, cycles each entry is held on the write port (≥1).
- `GAP_CYCLES`, 1, cycles of all-zero idle code driven after each entry (≥1).
- `FIFO_DEPTH_BITS`, 2, log2 of the entry FIFO depth.
- Interface: one clock; reset is asynchronous and active-high.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `wr_req`  in  1  entry write request; held until acked.
- `wr_addr`  in  14  target table address.
- `wr_data`  in  15  entry value.
- `wr_ack`  out  1  one-cycle pulse: entry consumed (queued or rejected).
- `clear_req`  in  1  one-cycle pulse requesting a bulk clear.
- `clear_busy`  out  1  high from clear accept until sweep done.
- `regex_din`  out  15  to `regex_match` write data.
- `regex_in_addr`  out  14  to `regex_match` write address.
- `loader_idle`  out  1  FIFO empty, FSM in IDLE, no clear pending.
- `entries_written`  out  16  entries driven on the port (saturating).
- `entries_rejected`  out  16  rejected entries (saturating).

## Operation
- Port protocol: `{regex_in_addr, regex_din} == 0` is the idle code; any nonzero pair is a write. Every entry is followed by ≥1 idle cycle, so back-to-back writes to the same address are seen as distinct.
- Entry `(addr 0, data 0)` is indistinguishable from idle: acked, not queued, `entries_rejected`++.
- Accept: `wr_req` high, FIFO not full, no clear pending/active → enqueue, `wr_ack` next cycle. FIFO full or clear pending/active → no ack; requester holds `wr_req`.
- FSM states: IDLE, HOLD, GAP, CLR_HOLD, CLR_GAP.
  - IDLE: clear pending and FIFO empty → load addr 1, data 0 → CLR_HOLD. Else FIFO non-empty → pop, register entry to outputs → HOLD.
  - HOLD: count `HOLD_CYCLES`; on last, outputs ← 0, `entries_written`++ → GAP.
  - GAP: count `GAP_CYCLES` → IDLE.
  - CLR_HOLD / CLR_GAP: same framing, data 0, address incrementing 1 → 2^14−1; after the last address's gap → IDLE, `clear_busy` low. Address 0 is not cleared (idle code).
- `clear_req` while a clear is pending/active: ignored. Entries already queued drain before the sweep starts.
- Counters saturate at 16'hFFFF; clear-sweep writes do not count.

## Timing
- Reset values: `regex_din`=0, `regex_in_addr`=0, `wr_ack`=0, `clear_busy`=0, `loader_idle`=1, counters=0; FIFO flushed. Reset mid-entry or mid-clear aborts immediately (async); outputs drop to idle code at once.
- `wr_req` sampled at edge E0 with space → `wr_ack` high E0–E1; FSM in IDLE pops at E1; outputs nonzero from E1 for `HOLD_CYCLES` cycles, then zero for `GAP_CYCLES`.
- Sustained throughput: one entry per `HOLD_CYCLES+GAP_CYCLES` cycles.
- Clear: `clear_busy` rises the cycle after `clear_req`; sweep takes (2^14−1)·(HOLD+GAP) cycles after FIFO drain.
- Simultaneous `wr_req` and `clear_req` at the same edge: the write is accepted and drains before the sweep.

## Structure
- Shared package/header: idle-code constant, entry bit positions (match flag 14, stage 12:0), FSM state encodings.
- Sub-module: `fallthrough_small_fifo` (WIDTH 29, MAX_DEPTH_BITS = `FIFO_DEPTH_BITS`) for entry buffering. Counters and FSM inline.

## Test plan
- Single write addr 14'h0041, data 15'h4003 → port shows {0041,4003} for 2 cycles, then 0 for 1 cycle; `entries_written`=1.
- Five back-to-back writes to addr 14'h0100 → five distinct 2-on/1-off frames, `wr_ack` withheld while FIFO full (depth 4), no entry lost.
- Write (addr 0, data 0) → `wr_ack` pulses, port stays idle, `entries_rejected`=1.
- `clear_req` with 2 entries queued → both entries driven first, then sweep addr 1..16383 with data 0; `clear_busy` high throughout; `wr_req` not acked until done.
- Reset asserted during HOLD of a clear → outputs zero same cycle, `clear_busy`=0, counters 0, `loader_idle`=1.
